// File: rtl/miner_ctrl_if.sv
// Job-offer bus between a work scheduler (master) and miner_ctrl (slave):
// one header/target/nonce-range job moves across when cfg_valid && cfg_ready.
interface miner_ctrl_if;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [639:0] cfg_header;
    logic [255:0] cfg_target;
    logic [31:0]  cfg_nonce_start;
    logic [31:0]  cfg_nonce_end;

    modport master (
        output cfg_valid,
        output cfg_header,
        output cfg_target,
        output cfg_nonce_start,
        output cfg_nonce_end,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_header,
        input  cfg_target,
        input  cfg_nonce_start,
        input  cfg_nonce_end,
        output cfg_ready
    );
endinterface

// File: rtl/miner_ctrl.sv
// Nonce-sweep controller driving one double-SHA256 core: reset, start, wait, compare.
// Optional watchdog on the core's done signal is enabled with `define MINER_WDOG_EN.
module miner_ctrl #(
    parameter int unsigned WDOG_CYCLES = 32'd1023
) (
    input  logic         clk,
    input  logic         rst_n,
    miner_ctrl_if.slave  cfg,
    input  logic         abort,
    output logic         core_rst_n,
    output logic         core_start,
    output logic [639:0] core_block,
    input  logic [255:0] core_hash,
    input  logic         core_done,
    output logic         busy,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic         exhausted,
    output logic         wdog_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CRST  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    // The nonce travels little-endian inside the header's last word.
    function automatic logic [31:0] bswap32(input logic [31:0] v);
        bswap32 = {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [255:0] brev256(input logic [255:0] v);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = v[255-8*i -: 8];
        end
        return r;
    endfunction

    logic [2:0]   state_q, state_d;
    logic [31:0]  nonce_q, nonce_d;
    logic [31:0]  end_q, end_d;
    logic [255:0] target_q, target_d;
    logic [255:0] hash_q, hash_d;
    logic [639:0] block_q, block_d;
    logic         found_q, found_d;
    logic [31:0]  found_nonce_q, found_nonce_d;
    logic         exhausted_q, exhausted_d;
    logic         core_rst_n_q, core_rst_n_d;
    logic         core_start_q, core_start_d;
    logic         busy_q, busy_d;
    logic         cfg_ready_q, cfg_ready_d;
    logic         hit_s;
    logic         last_s;
    logic         unused_hdr_s;
`ifdef MINER_WDOG_EN
    logic [31:0]  wdog_cnt_q, wdog_cnt_d;
    logic         wdog_err_q, wdog_err_d;
`endif

    // Header bits [31:0] are always replaced by the swept nonce.
    assign unused_hdr_s = ^cfg.cfg_header[31:0];

    assign hit_s  = (brev256(hash_q) <= target_q);
    assign last_s = (nonce_q == end_q);

    // Next-state, job bookkeeping and registered-output decode.
    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        end_d         = end_q;
        target_d      = target_q;
        hash_d        = hash_q;
        block_d       = block_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        exhausted_d   = exhausted_q;
`ifdef MINER_WDOG_EN
        wdog_cnt_d    = wdog_cnt_q;
        wdog_err_d    = wdog_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cfg.cfg_valid && !abort) begin
                    target_d    = cfg.cfg_target;
                    end_d       = cfg.cfg_nonce_end;
                    nonce_d     = cfg.cfg_nonce_start;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
`ifdef MINER_WDOG_EN
                    wdog_err_d  = 1'b0;
`endif
                    if (cfg.cfg_nonce_start > cfg.cfg_nonce_end) begin
                        exhausted_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        block_d = {cfg.cfg_header[639:32], bswap32(cfg.cfg_nonce_start)};
                        state_d = ST_CRST;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CRST: begin
                state_d = ST_START;
            end
            ST_START: begin
`ifdef MINER_WDOG_EN
                wdog_cnt_d = 32'd1;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    hash_d  = core_hash;
                    state_d = ST_CHECK;
                end else begin
`ifdef MINER_WDOG_EN
                    // Counter holds cycles elapsed since core_start; trip as it reaches the limit.
                    if (wdog_cnt_q >= (WDOG_CYCLES - 32'd1)) begin
                        wdog_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + 32'd1;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_CHECK: begin
                if (hit_s) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                    state_d       = ST_IDLE;
                end else if (last_s) begin
                    exhausted_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    block_d = {block_q[639:32], bswap32(nonce_q + 32'd1)};
                    state_d = ST_CRST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over any completion decided in the same cycle and reports nothing.
        if (abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            found_d       = found_q;
            found_nonce_d = found_nonce_q;
            exhausted_d   = exhausted_q;
`ifdef MINER_WDOG_EN
            wdog_err_d    = wdog_err_q;
`endif
        end else begin
            state_d = state_d;
        end

        busy_d       = (state_d != ST_IDLE);
        cfg_ready_d  = (state_d == ST_IDLE);
        core_rst_n_d = !((state_d == ST_IDLE) || (state_d == ST_CRST));
        core_start_d = (state_d == ST_START);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            nonce_q       <= 32'd0;
            end_q         <= 32'd0;
            target_q      <= 256'd0;
            hash_q        <= 256'd0;
            block_q       <= 640'd0;
            found_q       <= 1'b0;
            found_nonce_q <= 32'd0;
            exhausted_q   <= 1'b0;
            core_rst_n_q  <= 1'b0;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            cfg_ready_q   <= 1'b1;
`ifdef MINER_WDOG_EN
            wdog_cnt_q    <= 32'd0;
            wdog_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            end_q         <= end_d;
            target_q      <= target_d;
            hash_q        <= hash_d;
            block_q       <= block_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            exhausted_q   <= exhausted_d;
            core_rst_n_q  <= core_rst_n_d;
            core_start_q  <= core_start_d;
            busy_q        <= busy_d;
            cfg_ready_q   <= cfg_ready_d;
`ifdef MINER_WDOG_EN
            wdog_cnt_q    <= wdog_cnt_d;
            wdog_err_q    <= wdog_err_d;
`endif
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign core_rst_n    = core_rst_n_q;
    assign core_start    = core_start_q;
    assign core_block    = block_q;
    assign busy          = busy_q;
    assign found         = found_q;
    assign found_nonce   = found_nonce_q;
    assign exhausted     = exhausted_q;
`ifdef MINER_WDOG_EN
    assign wdog_err      = wdog_err_q;
`else
    assign wdog_err      = 1'b0;
`endif

endmodule

// File: tb/tb_miner_ctrl.sv
// Bench for miner_ctrl: a stand-in hash core with per-nonce pseudo hashes,
// a reference sweep over the nonce range, and directed abort/reset/watchdog steps.
module tb_miner_ctrl;

    localparam logic [639:0] GEN_HDR = 640'h01000000_0000000000000000000000000000000000000000000000000000000000000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
    localparam logic [255:0] GEN_NUM = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] GEN_TGT = {48'h00000000FFFF, 208'd0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         abort;
    logic         core_rst_n;
    logic         core_start;
    logic [639:0] core_block;
    logic [255:0] core_hash = 256'd0;
    logic         core_done = 1'b0;
    logic         busy;
    logic         found;
    logic [31:0]  found_nonce;
    logic         exhausted;
    logic         wdog_err;

    miner_ctrl_if cfg_if();

    miner_ctrl #(.WDOG_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg         (cfg_if),
        .abort       (abort),
        .core_rst_n  (core_rst_n),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_hash   (core_hash),
        .core_done   (core_done),
        .busy        (busy),
        .found       (found),
        .found_nonce (found_nonce),
        .exhausted   (exhausted),
        .wdog_err    (wdog_err)
    );

    initial forever #5 clk = ~clk;

    int           n_total = 0;
    int           n_pass  = 0;
    int           n_fail  = 0;
    int           lat     = 0;
    bit           hang    = 1'b0;
    bit           genesis_mode = 1'b0;
    logic [31:0]  seed    = 32'd0;
    logic [639:0] blk_q[$];

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [255:0] byte_rev(input logic [255:0] v);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 32; i++) r[255-8*i -: 8] = v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mix32(input logic [31:0] a);
        logic [31:0] x;
        x = a;
        x = x ^ (x >> 16);
        x = x * 32'h7feb352d;
        x = x ^ (x >> 15);
        x = x * 32'h846ca68b;
        x = x ^ (x >> 16);
        return x;
    endfunction

    // Numeric (display-order) hash the stand-in core reports for a nonce.
    function automatic logic [255:0] hnum(input logic [31:0] n);
        logic [255:0] h;
        h = 256'd0;
        if (genesis_mode && (n == 32'h7C2BAC1D)) return GEN_NUM;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = mix32(n ^ seed ^ (32'h01000193 * 32'(i)));
        return h;
    endfunction

    // Stand-in core: done pulses lat+1 cycles after core_start, digest in wire order.
    initial begin
        int          cnt;
        bit          pend;
        logic [31:0] cur;
        cnt = 0;
        pend = 1'b0;
        cur = 32'd0;
        forever begin
            @(negedge clk);
            if (core_done) core_done = 1'b0;
            if (core_rst_n !== 1'b1) begin
                pend = 1'b0;
            end else if (core_start === 1'b1) begin
                blk_q.push_back(core_block);
                cur  = bswap(core_block[31:0]);
                cnt  = lat;
                pend = !hang;
            end else if (pend) begin
                if (cnt == 0) begin
                    core_hash = byte_rev(hnum(cur));
                    core_done = 1'b1;
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [639:0] hdr, input logic [255:0] tgt,
                         input logic [31:0] ns, input logic [31:0] ne);
        @(negedge clk);
        cfg_if.cfg_valid       = 1'b1;
        cfg_if.cfg_header      = hdr;
        cfg_if.cfg_target      = tgt;
        cfg_if.cfg_nonce_start = ns;
        cfg_if.cfg_nonce_end   = ne;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},        640'(busy),             640'(0));
        check({tag, " cfg_ready"},   640'(cfg_if.cfg_ready), 640'(1));
        check({tag, " core_rst_n"},  640'(core_rst_n),       640'(0));
        check({tag, " core_start"},  640'(core_start),       640'(0));
        check({tag, " core_block"},  core_block,             640'(0));
        check({tag, " found"},       640'(found),            640'(0));
        check({tag, " found_nonce"}, 640'(found_nonce),      640'(0));
        check({tag, " exhausted"},   640'(exhausted),        640'(0));
        check({tag, " wdog_err"},    640'(wdog_err),         640'(0));
    endtask

    // Runs one job to completion and compares against a plain sweep of the range.
    task automatic run_job(input string name, input logic [639:0] hdr, input logic [255:0] tgt,
                           input logic [31:0] ns, input logic [31:0] ne, input int lat_i);
        bit          ef;
        logic [31:0] en;
        int          natt;
        int          cyc;
        ef = 1'b0;
        en = 32'd0;
        natt = 0;
        for (longint n = longint'(ns); n <= longint'(ne); n++) begin
            natt++;
            if (hnum(n[31:0]) <= tgt) begin
                ef = 1'b1;
                en = n[31:0];
                break;
            end
        end
        lat = lat_i;
        blk_q.delete();
        offer(hdr, tgt, ns, ne);
        if (ns > ne) begin
            check({name, " exhausted"}, 640'(exhausted), 640'(1));
            check({name, " busy"},      640'(busy),      640'(0));
            check({name, " found"},     640'(found),     640'(0));
            repeat (3) @(negedge clk);
            check({name, " starts"},    640'(blk_q.size()), 640'(0));
        end else begin
            check({name, " busy@accept"}, 640'(busy), 640'(1));
            check({name, " ready@accept"}, 640'(cfg_if.cfg_ready), 640'(0));
            check({name, " found cleared"}, 640'(found), 640'(0));
            cyc = 1;
            while ((busy === 1'b1) && (cyc < natt * (lat_i + 4) + 50)) begin
                @(negedge clk);
                if (busy === 1'b1) cyc++;
            end
            check({name, " busy cycles"}, 640'(cyc), 640'(natt * (lat_i + 4)));
            check({name, " found"},     640'(found),     640'(ef));
            check({name, " exhausted"}, 640'(exhausted), 640'(!ef));
            check({name, " wdog_err"},  640'(wdog_err),  640'(0));
            check({name, " starts"},    640'(blk_q.size()), 640'(natt));
            check({name, " core_rst_n idle"}, 640'(core_rst_n), 640'(0));
            if (ef) check({name, " found_nonce"}, 640'(found_nonce), 640'(en));
            for (int i = 0; i < blk_q.size() && i < natt; i++)
                check($sformatf("%s block%0d", name, i), blk_q[i], {hdr[639:32], bswap(ns + 32'(i))});
        end
    endtask

    initial begin
        logic [639:0] hdr;
        logic [255:0] tgt;
        logic [31:0]  s;
        logic [31:0]  e;
        longint       ee;
        int           len;
        int           nst;
        int           b;

        rst_n = 1'b0;
        abort = 1'b0;
        cfg_if.cfg_valid       = 1'b0;
        cfg_if.cfg_header      = 640'd0;
        cfg_if.cfg_target      = 256'd0;
        cfg_if.cfg_nonce_start = 32'd0;
        cfg_if.cfg_nonce_end   = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset ready", 640'(cfg_if.cfg_ready), 640'(1));
        check("post-reset busy",  640'(busy),             640'(0));

        genesis_mode = 1'b1;
        seed = $urandom;
        run_job("genesis", GEN_HDR, GEN_TGT, 32'h7C2BAC1A, 32'h7C2BAC20, 2);
        check("genesis nonce const", 640'(found_nonce), 640'(32'h7C2BAC1D));
        check("genesis attempts",    640'(blk_q.size()), 640'(4));
        check("genesis block hit",   blk_q[3], GEN_HDR);

        run_job("genesis_low", GEN_HDR, GEN_TGT, 32'h0, 32'h3, 1);
        check("low exhausted const", 640'(exhausted), 640'(1));
        check("low found const",     640'(found),     640'(0));
        check("low attempts",        640'(blk_q.size()), 640'(4));

        run_job("rev_range", GEN_HDR, GEN_TGT, 32'd5, 32'd2, 0);
        genesis_mode = 1'b0;

        hdr = 640'd0;
        for (int w = 0; w < 20; w++) hdr[32*w +: 32] = $urandom;
        run_job("top_nonce", hdr, {256{1'b1}}, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
        check("top found_nonce", 640'(found_nonce), 640'(32'hFFFFFFFF));
        repeat (5) @(negedge clk);
        check("found sticky", 640'(found), 640'(1));

        for (int k = 0; k < 10; k++) begin
            seed = $urandom;
            for (int w = 0; w < 20; w++) hdr[32*w +: 32] = $urandom;
            s   = (k == 4) ? 32'hFFFFFFFC : $urandom;
            len = $urandom_range(7);
            ee  = longint'(s) + longint'(len);
            e   = (ee > 64'h00000000FFFFFFFF) ? 32'hFFFFFFFF : ee[31:0];
            tgt = {$urandom_range(32'h60000000), {224{1'b1}}};
            run_job($sformatf("rand%0d", k), hdr, tgt, s, e, int'($urandom_range(5)));
        end

        // Abort while waiting on the second attempt's hash.
        lat = 8;
        blk_q.delete();
        offer(hdr, 256'd0, 32'd0, 32'd20);
        nst = 0;
        b = 0;
        while ((nst < 2) && (b < 200)) begin
            @(negedge clk);
            b++;
            if (core_start === 1'b1) nst++;
        end
        check("abort attempt2 reached", 640'(nst), 640'(2));
        repeat (2) @(negedge clk);
        check("abort pre busy",   640'(busy),       640'(1));
        check("abort pre core_rst_n", 640'(core_rst_n), 640'(1));
        abort = 1'b1;
        @(negedge clk);
        check("abort busy",       640'(busy),             640'(0));
        check("abort ready",      640'(cfg_if.cfg_ready), 640'(1));
        check("abort core_rst_n", 640'(core_rst_n),       640'(0));
        check("abort found",      640'(found),            640'(0));
        check("abort exhausted",  640'(exhausted),        640'(0));
        check("abort wdog_err",   640'(wdog_err),         640'(0));
        abort = 1'b0;
        repeat (10) @(negedge clk);
        check("abort no restart", 640'(blk_q.size()), 640'(2));

        run_job("pre_reset", hdr, {256{1'b1}}, 32'h00001234, 32'h00001240, 1);

        // Reset pulsed in the middle of a job.
        lat = 3;
        offer(hdr, 256'd0, 32'd100, 32'd200);
        repeat (6) @(negedge clk);
        check("midjob busy", 640'(busy), 640'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midjob reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after reset busy", 640'(busy), 640'(0));
        seed = $urandom;
        run_job("after_reset", hdr, {32'h40000000, {224{1'b1}}}, 32'd7, 32'd12, 2);

`ifdef MINER_WDOG_EN
        hang = 1'b1;
        offer(hdr, 256'd0, 32'd0, 32'd5);
        b = 0;
        while ((core_start !== 1'b1) && (b < 20)) begin
            @(negedge clk);
            b++;
        end
        check("wdog start seen", 640'(core_start), 640'(1));
        b = 0;
        while ((wdog_err !== 1'b1) && (b < 40)) begin
            @(negedge clk);
            b++;
        end
        check("wdog delay",     640'(b),         640'(16));
        check("wdog busy",      640'(busy),      640'(0));
        check("wdog found",     640'(found),     640'(0));
        check("wdog exhausted", 640'(exhausted), 640'(0));
        hang = 1'b0;
`else
        check("wdog tied", 640'(wdog_err), 640'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
